hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Detects load-use hazards that forwarding cannot cover and inserts one bubble. Flushes wrong-path instructions on a taken branch. Freezes the front of the pipeline while a multi-cycle multiply/divide runs in EX. Sits beside the forwarding unit and drives the write-enable and flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
- MULT_LAT, 4: EX occupancy of a multiply in cycles, ≥1.
- DIV_LAT, 8: EX occupancy of a divide in cycles, ≥1.
- CNT_W, 5: down-counter width; must hold max(MULT_LAT, DIV_LAT)-1.

- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- memReadEX  in  1  instruction in EX is a load.
- regWriteAddrEX  in  5  destination register of the instruction in EX.
- rsAddrID, rtAddrID  in  5 each  source registers of the instruction in ID.
- useRsID, useRtID  in  1 each  ID instruction actually reads rs / rt.
- branchTakenEX  in  1  branch/jump in EX resolved taken.
- mduStartEX  in  1  instruction in EX is mult/div.
- mduOp  in  1  0 = multiply, 1 = divide; valid with mduStartEX.
- pcWrite  out  1  PC update enable.
- ifidWrite  out  1  IF/ID load enable.
- ifidFlush  out  1  IF/ID cleared to NOP.
- idexWrite  out  1  ID/EX load enable.
- idexFlush  out  1  ID/EX cleared to NOP.
- exmemFlush  out  1  EX/MEM loaded with NOP.
- mduDone  out  1  last cycle of an MDU operation; the result is valid.

## Operation
- States: RUN and MDU_WAIT. Counter cnt[CNT_W-1:0]. All outputs are combinational from state, cnt and inputs.
- Defaults in RUN with no event: pcWrite=ifidWrite=idexWrite=1; all flushes=0; mduDone=0.
- Load-use hazard (RUN only) is true when all of these hold:
  - memReadEX=1 and regWriteAddrEX≠0;
  - (useRsID and rsAddrID==regWriteAddrEX) or (useRtID and rtAddrID==regWriteAddrEX).
- On load-use: pcWrite=0, ifidWrite=0, idexFlush=1 for exactly one cycle. The condition then clears by itself.
- Branch taken (RUN): ifidFlush=1, idexFlush=1, pcWrite=1. It has priority over load-use. It also has priority over mduStartEX, which is ignored in that cycle.
- MDU start (RUN, mduStartEX=1, no branch): LAT = mduOp ? DIV_LAT : MULT_LAT.
  - LAT==1: no stall; mduDone=1 in the same cycle; stay in RUN.
  - LAT>1: stall this cycle, load cnt←LAT-2, go to MDU_WAIT.
  - Stall means pcWrite=ifidWrite=idexWrite=0 and exmemFlush=1. Load-use is masked.
- MDU_WAIT:
  - cnt≠0: stall; cnt←cnt-1.
  - cnt==0: mduDone=1, stall released (defaults), next state RUN.
  - All other inputs are ignored in MDU_WAIT.
- Net effect: the MDU instruction occupies EX for exactly LAT cycles.

## Timing
- Reset (rst_n=0, asynchronous): state=RUN, cnt=0. Outputs immediately take the RUN defaults, with mduDone=0 and flushes=0 given idle inputs.
- Reset asserted mid-MDU abandons the operation and returns to RUN with no mduDone.
- Load-use bubble costs 1 cycle. Branch penalty is 2 cycles, both flushed in the resolve cycle.
- mduStartEX stays high while its instruction is frozen in EX. It is not re-sampled until the state is RUN again, one cycle after mduDone.

## Configuration
- HAZARD_STATS_EN, when defined, adds two outputs:
  - loadUseCnt[15:0]: counts load-use bubbles.
  - mduStallCnt[15:0]: counts MDU stall cycles.
  - Both are saturating at 16'hFFFF and reset to 0 by rst_n.
- When HAZARD_STATS_EN is undefined, these ports and counters do not exist and behaviour is otherwise identical.

## Test plan
- lw $t0 in EX (memReadEX=1, regWriteAddrEX=8), ID reads rs=8 with useRsID=1 -> one cycle pcWrite=0, ifidWrite=0, idexFlush=1; the next cycle has defaults.
- Same case with regWriteAddrEX=0, or with useRsID=0 and useRtID=0 -> no stall.
- branchTakenEX=1 together with a load-use condition -> ifidFlush=1, idexFlush=1, pcWrite=1.
- mduStartEX=1, mduOp=1, DIV_LAT=8 -> stall for cycles 0..6; mduDone=1 in cycle 7 with pcWrite=1; RUN in cycle 8. Repeat with MULT_LAT=1 -> mduDone in the same cycle, no stall.
- Start a divide, pull rst_n low in cycle 3 -> outputs return to defaults immediately, state=RUN, no mduDone.
- With HAZARD_STATS_EN: 3 load-use events and 1 divide -> loadUseCnt=3, mduStallCnt=7.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage MIPS core.
// Inserts a one-cycle bubble on load-use hazards and flushes IF/ID and ID/EX
// on a taken branch. Freezes PC, IF/ID and ID/EX while a multi-cycle
// multiply/divide occupies EX.
// Optional build macro: HAZARD_STATS_EN adds the saturating event counters
// loadUseCnt and mduStallCnt.
module hazard_ctrl #(
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 8,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             memReadEX,
   input  logic [4:0]       regWriteAddrEX,
   input  logic [4:0]       rsAddrID,
   input  logic [4:0]       rtAddrID,
   input  logic             useRsID,
   input  logic             useRtID,
   input  logic             branchTakenEX,
   input  logic             mduStartEX,
   input  logic             mduOp,
   output logic             pcWrite,
   output logic             ifidWrite,
   output logic             ifidFlush,
   output logic             idexWrite,
   output logic             idexFlush,
   output logic             exmemFlush,
   output logic             mduDone
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]      loadUseCnt,
   output logic [15:0]      mduStallCnt
`endif
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } stateT;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // The first EX cycle is spent in RUN, the last one (cnt==0) signals done,
   // so the counter is preloaded with LAT-2.
   localparam logic [CNT_W-1:0] MULT_LOAD = (MULT_LAT > 1) ? CNT_W'(MULT_LAT - 2) : CNT_ZERO;
   localparam logic [CNT_W-1:0] DIV_LOAD  = (DIV_LAT > 1)  ? CNT_W'(DIV_LAT - 2)  : CNT_ZERO;
   localparam logic             MULT_SINGLE = (MULT_LAT == 1);
   localparam logic             DIV_SINGLE  = (DIV_LAT == 1);

   stateT            stateR;
   stateT            stateNxt;
   logic [CNT_W-1:0] cntR;
   logic [CNT_W-1:0] cntNxt;

   logic             loadUseHit;
   logic             mduSingle;
   logic [CNT_W-1:0] mduLoad;

   logic             stallS;
   logic             bubbleS;
   logic             branchS;
   logic             doneS;

   // Decode the load-use condition and the latency of the requested MDU op
   always_comb begin
      loadUseHit = 1'b0;
      mduSingle  = MULT_SINGLE;
      mduLoad    = MULT_LOAD;
      if (memReadEX && (regWriteAddrEX != 5'd0)) begin
         loadUseHit = (useRsID && (rsAddrID == regWriteAddrEX)) ||
                      (useRtID && (rtAddrID == regWriteAddrEX));
      end else begin
         loadUseHit = 1'b0;
      end
      if (mduOp) begin
         mduSingle = DIV_SINGLE;
         mduLoad   = DIV_LOAD;
      end else begin
         mduSingle = MULT_SINGLE;
         mduLoad   = MULT_LOAD;
      end
   end

   // State and MDU down-counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateR <= RUN;
         cntR   <= CNT_ZERO;
      end else begin
         stateR <= stateNxt;
         cntR   <= cntNxt;
      end
   end

   // Next-state and counter update; a taken branch kills a concurrent MDU start
   always_comb begin
      stateNxt = stateR;
      cntNxt   = cntR;
      case (stateR)
         RUN: begin
            if (branchTakenEX) begin
               stateNxt = RUN;
               cntNxt   = CNT_ZERO;
            end else if (mduStartEX && !mduSingle) begin
               stateNxt = MDU_WAIT;
               cntNxt   = mduLoad;
            end else begin
               stateNxt = RUN;
               cntNxt   = CNT_ZERO;
            end
         end
         MDU_WAIT: begin
            if (cntR != CNT_ZERO) begin
               stateNxt = MDU_WAIT;
               cntNxt   = cntR - CNT_ONE;
            end else begin
               stateNxt = RUN;
               cntNxt   = CNT_ZERO;
            end
         end
         default: begin
            stateNxt = RUN;
            cntNxt   = CNT_ZERO;
         end
      endcase
   end

   // Pipeline controls from state, counter and hazard inputs
   always_comb begin
      stallS  = 1'b0;
      bubbleS = 1'b0;
      branchS = 1'b0;
      doneS   = 1'b0;
      case (stateR)
         RUN: begin
            if (branchTakenEX) begin
               branchS = 1'b1;
            end else if (mduStartEX) begin
               if (mduSingle) begin
                  doneS = 1'b1;
               end else begin
                  stallS = 1'b1;
               end
            end else if (loadUseHit) begin
               bubbleS = 1'b1;
            end else begin
               stallS = 1'b0;
            end
         end
         MDU_WAIT: begin
            if (cntR != CNT_ZERO) begin
               stallS = 1'b1;
            end else begin
               doneS = 1'b1;
            end
         end
         default: begin
            stallS = 1'b0;
         end
      endcase
      pcWrite    = !(stallS || bubbleS);
      ifidWrite  = !(stallS || bubbleS);
      ifidFlush  = branchS;
      idexWrite  = !stallS;
      idexFlush  = branchS || bubbleS;
      exmemFlush = stallS;
      mduDone    = doneS;
   end

`ifdef HAZARD_STATS_EN
   // Saturating counters of load-use bubbles and MDU stall cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loadUseCnt  <= 16'h0000;
         mduStallCnt <= 16'h0000;
      end else begin
         if (bubbleS && (loadUseCnt != 16'hFFFF)) begin
            loadUseCnt <= loadUseCnt + 16'h0001;
         end else begin
            loadUseCnt <= loadUseCnt;
         end
         if (stallS && (mduStallCnt != 16'hFFFF)) begin
            mduStallCnt <= mduStallCnt + 16'h0001;
         end else begin
            mduStallCnt <= mduStallCnt;
         end
      end
   end
`endif

endmodule
